// File: rtl/bin_serializer_2_10.sv
// rtl/bin_serializer_2_10.sv - MSB-first bit feeder and enable/drain sequencer for the bit-serial BCD digit array
// Optional overflow flag enabled by defining BIN_SER_OVF_CHECK_EN.
module bin_serializer_2_10 #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 3,
  parameter int PIPE_LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  output logic             bit_out,
  output logic             ena_out,
  output logic             bit_valid,
  output logic             sof,
  output logic             done,
  output logic             ovf
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = $clog2(PIPE_LAT + 2);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  // A stalled cycle leaves every register untouched, so bit_out keeps showing the pending bit.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d    = in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          sreg_d = sreg_q << 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            drain_cnt_d = '0;
            if (PIPE_LAT == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (drain_cnt_q == LAST_DRAIN) begin
            drain_cnt_d = '0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign ena_out   = (state_q != IDLE) && !stall;
  assign bit_valid = (state_q == SHIFT) && !stall;
  assign sof       = (state_q == SHIFT) && (bit_cnt_q == '0) && !stall;
  assign bit_out   = (state_q == SHIFT) && sreg_q[WIDTH-1];
  assign done      = done_q;

`ifdef BIN_SER_OVF_CHECK_EN
  localparam logic [WIDTH+3:0] OVF_LIMIT = (WIDTH + 4)'(10 ** NUM_DIGITS);

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = ({4'b0000, in_data} >= OVF_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = done_q && ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin_serializer_2_10.sv
// tb/tb_bin_serializer_2_10.sv - directed self-checking bench for bin_serializer_2_10
module tb_bin_serializer_2_10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_data = '0;
  logic       stall = 1'b0;
  logic       bit_out, ena_out, bit_valid, sof, done, ovf;
  logic [6:0] obs;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // {in_ready, bit_out, ena_out, bit_valid, sof, done, ovf}
  localparam logic [6:0] RST_VEC = 7'b1000000;

`ifdef BIN_SER_OVF_CHECK_EN
  localparam logic OVF_1000 = 1'b1;
`else
  localparam logic OVF_1000 = 1'b0;
`endif

  bin_serializer_2_10 #(.WIDTH(10), .NUM_DIGITS(3), .PIPE_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .stall     (stall),
    .bit_out   (bit_out),
    .ena_out   (ena_out),
    .bit_valid (bit_valid),
    .sof       (sof),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  assign obs = {in_ready, bit_out, ena_out, bit_valid, sof, done, ovf};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the current (idle) cycle; the accept happens at its closing edge.
  task automatic do_word(input string tag, input logic [9:0] data, input logic [9:0] bits,
                         input logic [31:0] smask, input int done_c, input logic exp_ovf,
                         input logic hold_v, input logic [9:0] hold_d, input int abort_at);
    int bi;
    logic st;
    logic [6:0] e;
    in_valid = 1'b1;
    in_data  = data;
    stall    = 1'b0;
    #1 check({tag, " acc_ready"}, 32'(in_ready), 32'd1);
    bi = 0;
    for (int c = 1; c <= done_c; c++) begin
      cyc();
      in_valid = hold_v;
      in_data  = hold_v ? hold_d : data;
      st       = smask[c];
      stall    = st;
      if (c == abort_at) begin
        #2 rst = 1'b0;
        #1 check($sformatf("%s c%0d rst", tag, c), 32'(obs), 32'(RST_VEC));
        stall    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      #4;
      if (c == done_c) begin
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_ovf};
      end else if (bi < 10) begin
        e = {1'b0, bits[9-bi], !st, !st, (bi == 0) && !st, 1'b0, 1'b0};
        if (!st) bi++;
      end else begin
        e = {1'b0, 1'b0, !st, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      check($sformatf("%s c%0d", tag, c), 32'(obs), 32'(e));
    end
    stall = 1'b0;
  endtask

  initial begin
    // reset held three cycles, then idle with stall toggling
    for (int i = 0; i < 3; i++) begin
      cyc();
      #4 check($sformatf("reset c%0d", i), 32'(obs), 32'(RST_VEC));
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      stall = i[0];
      #4 check($sformatf("idle c%0d", i), 32'(obs), 32'(RST_VEC));
    end
    stall = 1'b0;

    cyc();
    do_word("w999", 10'd999, 10'b1111100111, 32'd0, 14, 1'b0, 1'b0, 10'd0, 0);
    cyc();
    do_word("w512stall", 10'd512, 10'b1000000000, 32'h18, 16, 1'b0, 1'b0, 10'd0, 0);

    cyc();
    do_word("b2b_a", 10'd999, 10'b1111100111, 32'd0, 14, 1'b0, 1'b1, 10'd5, 0);
    do_word("b2b_b", 10'd5, 10'b0000000101, 32'd0, 14, 1'b0, 1'b0, 10'd0, 0);

    cyc();
    do_word("w1000", 10'd1000, 10'b1111101000, 32'd0, 14, OVF_1000, 1'b0, 10'd0, 0);

    cyc();
    do_word("abort", 10'd999, 10'b1111100111, 32'd0, 14, 1'b0, 1'b0, 10'd0, 12);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #4 check($sformatf("post_abort c%0d", i), 32'(obs), 32'(RST_VEC));
      cyc();
    end
    do_word("w300", 10'd300, 10'b0100101100, 32'd0, 14, 1'b0, 1'b0, 10'd0, 0);
    cyc();
    #4 check("after_done", 32'(obs), 32'(RST_VEC));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
